im_loader: RTL
==============

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter DWL, default 32: instruction word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter AWL, default 32: write-address width in bits.
REQ-003 SHALL have parameter DEPTH, default 32: number of instruction-memory words that can be written.
REQ-004 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a load.
REQ-007 SHALL have port word_count, input, AWL: number of words to load; sampled when start is accepted.
REQ-008 SHALL have port abort, input, 1: synchronous cancel of an active load.
REQ-009 SHALL have port byte_valid, input, 1: byte_data holds a valid byte.
REQ-010 SHALL have port byte_data, input, 8: incoming instruction byte.
REQ-011 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-012 SHALL have port we, output, 1: instruction-memory write strobe.
REQ-013 SHALL have port waddr, output, AWL: word index being written.
REQ-014 SHALL have port wdata, output, DWL: assembled instruction word.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when the load completes.
REQ-017 SHALL have port err, output, 1: one-cycle pulse when start carries an illegal word_count.

Function
REQ-018 SHALL implement exactly four states: IDLE, LOAD, WRITE, DONE; all outputs registered.
REQ-019 IDLE: on start with 1 <= word_count <= DEPTH, SHALL latch word_count, clear the word counter (waddr=0) and the byte index, and go to LOAD.
REQ-020 IDLE: on start with word_count 0 or greater than DEPTH, SHALL pulse err for one cycle and stay in IDLE.
REQ-021 LOAD: byte_ready SHALL be 1; byte_ready SHALL be 0 in all other states.
REQ-022 LOAD: a byte SHALL transfer only when byte_valid and byte_ready are both 1; byte_valid without byte_ready SHALL be ignored.
REQ-023 Byte assembly SHALL be big-endian: the first accepted byte lands in wdata[DWL-1:DWL-8]; the assembly register shifts left by 8 per byte.
REQ-024 On acceptance of byte DWL/8 of a word, the FSM SHALL go to WRITE on the next edge.
REQ-025 WRITE: we=1 for exactly one cycle, with waddr = current word index and wdata = assembled word.
REQ-026 After WRITE, the FSM SHALL go to DONE if the words written equal the latched count; otherwise it SHALL increment waddr and return to LOAD.
REQ-027 DONE: done=1 for one cycle, then the FSM SHALL return to IDLE; waddr holds the last written index.
REQ-028 Minimum throughput SHALL be DWL/8+1 cycles per word (4 byte cycles + 1 write cycle at DWL=32).
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort in LOAD or WRITE SHALL return the FSM to IDLE on the next edge: no we in that cycle, no done pulse, partial word discarded; words already written remain.
REQ-031 If abort and the final byte arrive in the same cycle, abort SHALL win: no write occurs.
REQ-032 waddr SHALL never exceed DEPTH-1 and SHALL never wrap.

Reset
REQ-033 While RST_N=0: FSM=IDLE; byte_ready, we, busy, done, err = 0; waddr, wdata, counters = 0.
REQ-034 Reset asserted mid-load SHALL take effect immediately, without waiting for a clock edge, and SHALL NOT produce a we pulse.

Structure
REQ-035 The state encoding and BYTES_PER_WORD (DWL/8) SHALL live in the shared package.
REQ-036 Sub-module im_byte_packer SHALL contain the shift register and byte index and SHALL flag word_full; the FSM and counters SHALL stay in im_loader.

Verification
REQ-037 start, word_count=2; bytes 20,10,00,05 then 00,00,58,20, each with byte_valid=1 -> we at waddr 0 with wdata 0x20100005, then at waddr 1 with wdata 0x00005820; done once; 10 cycles from first byte to done.
REQ-038 start, word_count=0, then word_count=33 -> err pulse each time; busy stays 0; no we.
REQ-039 word_count=1, byte_valid toggled 1,0,1,0,... -> only valid bytes are accepted; a single we with the correct word.
REQ-040 word_count=3; abort asserted together with the 4th byte of word 1 -> exactly one we (waddr 0); FSM in IDLE; no done.
REQ-041 RST_N driven low between clock edges while in LOAD -> all outputs 0 immediately; a new start then loads from waddr 0.
REQ-042 word_count=DEPTH (32) -> 32 we pulses at waddr 0..31; done; waddr ends at 31.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
package im_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DWL_DEF = 32;

  function automatic int bytes_per_word(input int dwl);
    return dwl / 8;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DWL_DEF);

endpackage

// File: rtl/im_byte_packer.sv
// Big-endian byte-to-word assembler: first byte lands in the top byte lane.
module im_byte_packer
  import im_loader_pkg::*;
#(
  parameter int DWL = 32
) (
  input  logic           gclk,
  input  logic           grst_n,
  input  logic           clr,
  input  logic           shift_en,
  input  logic [7:0]     byte_data,
  output logic [DWL-1:0] word,
  output logic           word_full
);

  localparam int BPW = bytes_per_word(DWL);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0] idx;

  // Flags the byte that completes the word, in the same cycle it is accepted.
  assign word_full = shift_en && (idx == IW'(BPW - 1));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx  <= '0;
      word <= '0;
    end else if (shift_en) begin
      word <= (word << 8) | DWL'(byte_data);
      idx  <= word_full ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/im_loader.sv
// Loads word_count instruction words from a byte stream into instruction memory.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int DWL   = 32,
  parameter int AWL   = 32,
  parameter int DEPTH = 32
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           start,
  input  logic [AWL-1:0] word_count,
  input  logic           abort,
  input  logic           byte_valid,
  input  logic [7:0]     byte_data,
  output logic           byte_ready,
  output logic           we,
  output logic [AWL-1:0] waddr,
  output logic [DWL-1:0] wdata,
  output logic           busy,
  output logic           done,
  output logic           err
);

  state_t         state;
  logic [AWL-1:0] last_idx;
  logic           cnt_ok;
  logic           active;
  logic           pk_clr;
  logic           pk_shift;
  logic           word_full;

  assign cnt_ok = (word_count != '0) && (word_count <= AWL'(DEPTH));
  assign active = (state == ST_LOAD) || (state == ST_WRITE);

  // Abort beats a simultaneous final byte, so the partial word never reaches WRITE.
  assign pk_shift = byte_ready && byte_valid && !abort;
  assign pk_clr   = ((state == ST_IDLE) && start && cnt_ok) || (active && abort);

  im_byte_packer #(.DWL(DWL)) u_packer (
    .gclk      (CLK),
    .grst_n    (RST_N),
    .clr       (pk_clr),
    .shift_en  (pk_shift),
    .byte_data (byte_data),
    .word      (wdata),
    .word_full (word_full)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      waddr      <= '0;
      last_idx   <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cnt_ok) begin
              state      <= ST_LOAD;
              last_idx   <= word_count - AWL'(1);
              waddr      <= '0;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
          end else if (word_full) begin
            state      <= ST_WRITE;
            byte_ready <= 1'b0;
            we         <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (waddr == last_idx) begin
            // last_idx <= DEPTH-1, so waddr stops there and never wraps.
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state      <= ST_LOAD;
            waddr      <= waddr + AWL'(1);
            byte_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
